pl_fetch_queue: RTL
===================

Name: pl_fetch_queue

Overview:
Parametrised decoupled instruction-fetch front end for the 5-stage RISC-V pipeline. It replaces the single fetch/IF-ID register pair with a fetch PC generator plus a DEPTH-entry instruction queue. It issues sequential requests to a fixed-1-cycle-latency instruction memory, buffers {pc, pc+4, inst} and hands entries to ID over a valid/ready handshake. Branch and jump redirects from ID flush all buffered and in-flight instructions.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  pipeline clock, rising edge
clrn  in  1  asynchronous active-low reset
imem_req  out  1  fetch request this cycle
imem_addr  out  XLEN  fetch address (= fpc)
imem_gnt  in  1  memory accepts request this cycle
imem_rdata  in  XLEN  instruction; valid exactly 1 cycle after an accepted request
redir  in  1  redirect from ID (pcsrc != 0)
redir_pc  in  XLEN  redirect target (bra/jalra/jala)
d_valid  out  1  queue head valid
d_ready  in  1  ID accepts head (low = wpcir stall)
d_pc  out  XLEN  head pc
d_pc4  out  XLEN  head pc+4
d_inst  out  XLEN  head instruction

Behaviour:
- Reset (clrn=0, async): fpc=RESET_PC, rd/wr pointers=0, count=0, inflight=0. d_valid=0, d_pc/d_pc4/d_inst=0, imem_req=0 while clrn low.
- Request: imem_req = !redir && (count + inflight < DEPTH). Pops in the same cycle are not credited; this is conservative by design. imem_addr = fpc.
- Accepted request (imem_req && imem_gnt): fpc <= fpc+4, modulo 2^XLEN with no carry out. inflight <= 1, and the captured address is stored for the response. Otherwise inflight <= 0.
- Response: in the cycle after acceptance with inflight=1 and no redir, write {addr, addr+4, imem_rdata} at wr_ptr. wr_ptr advances mod DEPTH.
- Latency: request accepted at cycle N, data written at N+1, d_valid=1 from N+2. There is no combinational bypass.
- Output: d_valid = (count != 0). d_pc/d_pc4/d_inst come from the head entry, or 0 when empty. Pop when d_valid && d_ready; rd_ptr advances mod DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pop when empty or push when full cannot occur. Assertion: push with count==DEPTH is an error.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- Redirect (redir=1) has priority over every other event in that cycle:
  - count <= 0 and rd_ptr <= wr_ptr; pop is ignored.
  - A response arriving in this cycle is discarded.
  - inflight <= 0 and fpc <= redir_pc.
  - No request is issued this cycle. The first request at redir_pc goes out the next cycle, so redirect-to-decode is 3 cycles.
- redir on consecutive cycles: the last target wins.
- imem_gnt=0: fpc holds and imem_req stays asserted while eligible. The memory sees a stable address.
- Reset asserted mid-operation clears all state immediately, including any pending response.

Optional Feature:
Macro PL_FQ_PERF_EN.
- Defined: adds output ports perf_flush_cnt[31:0] and perf_empty_cnt[31:0], both reset to 0.
  - perf_flush_cnt increments on each redir cycle that discards at least one buffered or in-flight entry.
  - perf_empty_cnt increments on each cycle with d_valid=0 && clrn=1.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist, and core behaviour is identical.

Test Plan:
1. Reset, d_ready=1, imem_gnt=1 steady → imem_addr 0,4,8,… each cycle. d_valid first high 2 cycles after the first request, d_pc=0/d_pc4=4, then one entry per cycle.
2. d_ready=0, DEPTH=4 → exactly 4 requests accepted (0..C). imem_req drops with count=4. On d_ready=1, pops of 0,4,8,C follow in order and requests resume at 0x10.
3. redir=1, redir_pc=0x100 while 3 entries are queued and one response is in flight → next cycle d_valid=0 and imem_addr=0x100. The next d_pc is 0x100; the stale instruction never appears.
4. imem_gnt=0 for 3 cycles at fpc=0x20 → imem_addr holds 0x20 and no entry is written. After gnt, 0x20 is delivered once.
5. Run for 10 pushes with alternating d_ready → pointer wrap is seamless and the d_pc sequence is contiguous. Push and pop in the same cycle keep count constant.
6. With PL_FQ_PERF_EN: 2 flushing redirects plus 5 empty cycles after reset → perf_flush_cnt=2 and perf_empty_cnt includes those 5 cycles.

Source files
------------

// File: rtl/pl_fetch_queue.sv
// pl_fetch_queue: decoupled instruction-fetch front end.
// A sequential fetch PC generator issues requests to a 1-cycle-latency
// instruction memory; responses land in a DEPTH-entry queue that ID drains
// over a valid/ready handshake. A redirect from ID flushes everything
// buffered or in flight and restarts fetch at the redirect target.
// Optional build macro: PL_FQ_PERF_EN adds flush and empty-cycle counters.
module pl_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            clrn,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redir,
  input  logic [XLEN-1:0] redir_pc,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [XLEN-1:0] d_pc,
  output logic [XLEN-1:0] d_pc4,
  output logic [XLEN-1:0] d_inst
`ifdef PL_FQ_PERF_EN
  ,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_empty_cnt
`endif
);

  localparam int unsigned        PTR_W     = $clog2(DEPTH);
  localparam int unsigned        CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]     DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fpc_q, fpc_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  raddr_q, raddr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  pc_mem_q   [DEPTH];
  logic [XLEN-1:0]  inst_mem_q [DEPTH];

  logic [CNT_W:0]   occupancy;
  logic             accept;
  logic             push;
  logic             pop;

  // Buffered entries plus the outstanding request; same-cycle pops are not
  // credited, so a full queue waits one extra cycle before fetching again.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req  = clrn && !redir && (occupancy < DEPTH_OCC);
  assign imem_addr = fpc_q;
  assign accept    = imem_req && imem_gnt;

  // A redirect kills the response arriving this cycle and ignores any pop.
  assign push    = inflight_q && !redir;
  assign d_valid = (count_q != '0);
  assign pop     = d_valid && d_ready && !redir;

  // Head entry, forced to zero when the queue is empty.
  assign d_pc   = d_valid ? pc_mem_q[rd_ptr_q]              : '0;
  assign d_pc4  = d_valid ? pc_mem_q[rd_ptr_q] + XLEN'(4)   : '0;
  assign d_inst = d_valid ? inst_mem_q[rd_ptr_q]            : '0;

  // Next-state logic for fetch PC, in-flight tracking, pointers and count.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    fpc_d      = fpc_q;
    inflight_d = 1'b0;
    raddr_d    = raddr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redir) begin
      fpc_d    = redir_pc;
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (accept) begin
        fpc_d      = fpc_q + XLEN'(4);
        inflight_d = 1'b1;
        raddr_d    = fpc_q;
      end
      // DEPTH is a power of two, so pointer increments wrap for free.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block evaluation order.
    if (!clrn) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      raddr_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      raddr_q    <= raddr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage write port.
  // NOTE: the entry array is deliberately not reset; count_q gates every read,
  // so stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= raddr_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Request throttling must make overflow impossible.
  push_when_full_a: assert property (@(posedge clk) disable iff (!clrn)
    !(push && !pop && (count_q == DEPTH_CNT)));

`ifdef PL_FQ_PERF_EN
  logic [31:0] perf_flush_q;
  logic [31:0] perf_empty_q;

  // Count flushing redirects and cycles where ID sees no instruction.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      perf_flush_q <= '0;
      perf_empty_q <= '0;
    end else begin
      if (redir && (d_valid || inflight_q)) perf_flush_q <= perf_flush_q + 32'd1;
      if (!d_valid)                         perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_flush_cnt = perf_flush_q;
  assign perf_empty_cnt = perf_empty_q;
`endif

endmodule
